// File: rtl/countn_updown.sv
// countn_updown: parametrised up/down counter with clamped load, synchronous
// clear, wrap or saturate at the boundaries, sticky overflow flag,
// combinational terminal count and a tri-state copy of the count.
module countn_updown #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             clr_l,
    input  logic             load_l,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             enable_l,
    input  logic             up_dn,
    input  logic             oe_l,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_tri,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
    localparam logic             SAT_C   = (SATURATE != 0);

    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;

    // Next-state: clear > load > count > hold; boundary steps set ovf.
    always_comb begin
        count_nxt = count;
        ovf_nxt   = ovf;
        if (!clr_l) begin
            count_nxt = RESET_C;
            ovf_nxt   = 1'b0;
        end else if (!load_l) begin
            count_nxt = (cnt_in > MAX_C) ? MAX_C : cnt_in;
            ovf_nxt   = 1'b0;
        end else if (!enable_l) begin
            if (up_dn) begin
                // Values above MAX_VAL (unreachable by counting) also take the boundary path.
                if (count >= MAX_C) begin
                    count_nxt = SAT_C ? MAX_C : '0;
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = count + ONE_C;
                end
            end else begin
                if (count == '0) begin
                    count_nxt = SAT_C ? '0 : MAX_C;
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = count - ONE_C;
                end
            end
        end
    end

    // Count and overflow registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count <= RESET_C;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Terminal count: the cycle whose counting edge will cross a boundary.
    assign tc = ~enable_l & ((up_dn & (count == MAX_C)) | (~up_dn & (count == '0)));

    // Shared-bus copy of the count, released when oe_l is high.
    assign count_tri = oe_l ? {WIDTH{1'bz}} : count;

endmodule
